// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: combs at the input rate, zero-stuff to R phases, integrators at clock rate.
// Define CIC_INTERP_ROUND_EN to round half up and saturate the output instead of truncating.
module cic_interpolator #(
    parameter int N = 3,
    parameter int R = 4,
    parameter int M = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [M-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [M-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam int LOG2R = $clog2(R);
    localparam int W     = M + N * LOG2R;
    localparam int S     = (N - 1) * LOG2R;

    logic [LOG2R-1:0]    phase;
    logic signed [W-1:0] comb_dly [N];
    logic signed [W-1:0] integ    [N];
    logic signed [W-1:0] comb_val [N+1];
    logic signed [W-1:0] inject;
    logic signed [M-1:0] scaled;
    logic                phase_zero;
    logic                space;
    logic                step;
    logic                accept;

    assign phase_zero = (phase == '0);
    assign space      = !out_valid || out_ready;
    assign step       = space && (in_valid || !phase_zero);
    assign in_ready   = space && phase_zero && !rst;
    assign accept     = in_valid && in_ready;

    // NOTE: comb_val[0] is assigned before any read, so the chain never holds a value and infers no latch.
    always_comb begin
        comb_val[0] = {{(W-M){in_data[M-1]}}, in_data};
        for (int k = 1; k <= N; k++) begin
            comb_val[k] = comb_val[k-1] - comb_dly[k-1];
        end
    end

    // Zero-stuffing: only the phase-0 step carries the comb output into the integrators.
    assign inject = phase_zero ? comb_val[N] : '0;

`ifdef CIC_INTERP_ROUND_EN
    localparam int                  Q    = W + 1 - S;
    localparam logic signed [W:0]   HALF = (W+1)'((64'(1) << S) >> 1);

    logic signed [W:0]   rounded;
    logic signed [Q-1:0] shifted;

    always_comb begin
        rounded = {integ[N-1][W-1], integ[N-1]} + HALF;
        shifted = rounded[W:S];
        if (&shifted[Q-1:M-1] || ~|shifted[Q-1:M-1]) begin
            scaled = shifted[M-1:0];
        end else if (shifted[Q-1]) begin
            scaled = {1'b1, {(M-1){1'b0}}};
        end else begin
            scaled = {1'b0, {(M-1){1'b1}}};
        end
    end
`else
    assign scaled = integ[N-1][S+M-1:S];
`endif

    // NOTE: every state element uses <= so all integrators update from the same old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < N; k++) begin
                comb_dly[k] <= '0;
                integ[k]    <= '0;
            end
        end else begin
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    comb_dly[k] <= comb_val[k];
                end
            end
            if (step) begin
                phase    <= phase + LOG2R'(1);
                integ[0] <= integ[0] + inject;
                for (int k = 1; k < N; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                out_data  <= scaled;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
